// File: rtl/ack_watchdog.sv
// Ack liveness watchdog: requires ack at least once per WINDOW armed cycles, counts acks, latches a sticky error.
// Optional min/max ack-interval statistics are enabled with `define ACK_WATCHDOG_STATS_EN.
module ack_watchdog #(
  parameter int WINDOW = 15,
  parameter int CNT_W  = 8,
  parameter int ACK_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             ack,
  input  logic             clear,
  output logic             armed,
  output logic             timeout,
  output logic             err,
  output logic [CNT_W-1:0] interval,
  output logic [ACK_W-1:0] ack_count
`ifdef ACK_WATCHDOG_STATS_EN
  ,
  output logic [CNT_W-1:0] min_interval,
  output logic [CNT_W-1:0] max_interval
`endif
);

  if (WINDOW < 2 || WINDOW >= (2 ** CNT_W)) begin : g_bad_window
    $error("ack_watchdog: WINDOW must lie in 2..2**CNT_W-1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_TRIPPED
  } state_e;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] interval_q, interval_d;
  logic [ACK_W-1:0] ack_count_q, ack_count_d;
  logic             timeout_q, timeout_d;
  logic             ack_counted;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d     = state_q;
    interval_d  = interval_q;
    ack_count_d = ack_count_q;
    timeout_d   = 1'b0;
    ack_counted = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        interval_d = '0;
        if (clear) begin
          ack_count_d = '0;
        end else if (enable) begin
          state_d = S_ARMED;
        end
      end

      S_ARMED: begin
        if (!enable) begin
          state_d    = S_IDLE;
          interval_d = '0;
          if (clear) ack_count_d = '0;
        end else if (clear) begin
          interval_d  = '0;
          ack_count_d = '0;
        end else if (ack) begin
          interval_d  = '0;
          ack_counted = 1'b1;
          if (!(&ack_count_q)) ack_count_d = ack_count_q + 1'b1;
        end else if (interval_q == LAST) begin
          // Interval freezes at LAST so the bound is visible while err is high.
          state_d   = S_TRIPPED;
          timeout_d = 1'b1;
        end else begin
          interval_d = interval_q + 1'b1;
        end
      end

      S_TRIPPED: begin
        if (clear) begin
          state_d     = S_IDLE;
          interval_d  = '0;
          ack_count_d = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      interval_q  <= '0;
      ack_count_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      interval_q  <= interval_d;
      ack_count_q <= ack_count_d;
      timeout_q   <= timeout_d;
    end
  end

  assign armed     = (state_q == S_ARMED);
  assign err       = (state_q == S_TRIPPED);
  assign timeout   = timeout_q;
  assign interval  = interval_q;
  assign ack_count = ack_count_q;

`ifdef ACK_WATCHDOG_STATS_EN
  logic [CNT_W-1:0] min_q, max_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      min_q <= '1;
      max_q <= '0;
    end else if (ack_counted) begin
      if (interval_q < min_q) min_q <= interval_q;
      if (interval_q > max_q) max_q <= interval_q;
    end
  end

  assign min_interval = min_q;
  assign max_interval = max_q;
`else
  logic unused_ack_counted;
  assign unused_ack_counted = ack_counted;
`endif

endmodule

// File: tb/tb_ack_watchdog.sv
// Directed self-checking bench for ack_watchdog (WINDOW=15, CNT_W=8, ACK_W=16).
module tb_ack_watchdog;
  localparam int WINDOW = 15;
  localparam int CNT_W  = 8;
  localparam int ACK_W  = 16;

  logic             clk = 1'b0;
  logic             rst, enable, ack, clear;
  logic             armed, timeout, err;
  logic [CNT_W-1:0] interval;
  logic [ACK_W-1:0] ack_count;
`ifdef ACK_WATCHDOG_STATS_EN
  logic [CNT_W-1:0] min_interval, max_interval;
`endif

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ack_watchdog #(.WINDOW(WINDOW), .CNT_W(CNT_W), .ACK_W(ACK_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .ack          (ack),
    .clear        (clear),
    .armed        (armed),
    .timeout      (timeout),
    .err          (err),
    .interval     (interval),
    .ack_count    (ack_count)
`ifdef ACK_WATCHDOG_STATS_EN
    ,
    .min_interval (min_interval),
    .max_interval (max_interval)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int          peak;
    logic        err_seen;
    int          first_to;
    int          pulses;
    logic [26:0] all_outs;

    rst = 1'b1; enable = 1'b1; ack = 1'b0; clear = 1'b0;

    // Reset ordering: outputs stay zero despite enable/ack activity.
    all_outs = '0;
    for (int i = 0; i < 4; i++) begin
      ack = ~ack;
      step();
      all_outs = all_outs | {armed, timeout, err, interval, ack_count};
    end
    check("reset_outputs_zero", 32'(all_outs), 32'd0);

    rst = 1'b0; ack = 1'b0;
    step();
    check("armed_after_reset", 32'(armed), 32'd1);
    check("interval_at_arm", 32'(interval), 32'd0);

    // Periodic ack on every 15th armed cycle, 100 periods.
    peak = 0; err_seen = 1'b0;
    for (int k = 0; k < 100; k++) begin
      for (int c = 0; c < WINDOW; c++) begin
        if (int'(interval) > peak) peak = int'(interval);
        ack = (c == WINDOW - 1);
        step();
        err_seen = err_seen | err | timeout;
      end
    end
    ack = 1'b0;
    check("periodic_no_err", 32'(err_seen), 32'd0);
    check("periodic_ack_count", 32'(ack_count), 32'd100);
    check("periodic_peak_interval", 32'(peak), 32'd14);

    // Boundary ack on interval==14 restarts the window.
    idle_cycles(14);
    check("boundary_interval_14", 32'(interval), 32'd14);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("boundary_interval_0", 32'(interval), 32'd0);
    check("boundary_ack_count", 32'(ack_count), 32'd101);
    check("boundary_no_trip", 32'({err, timeout, armed}), 32'b001);

    // Disarm keeps ack_count, then re-arm and miss every ack.
    enable = 1'b0;
    step();
    check("disarm_state", 32'({armed, interval}), 32'd0);
    check("disarm_keeps_count", 32'(ack_count), 32'd101);
    enable = 1'b1;
    step();
    first_to = -1; pulses = 0;
    for (int n = 1; n <= 25; n++) begin
      step();
      if (timeout) begin
        pulses++;
        if (first_to < 0) first_to = n;
      end
    end
    check("timeout_cycle", 32'(first_to), 32'd15);
    check("timeout_pulses", 32'(pulses), 32'd1);
    check("tripped_err", 32'({err, armed}), 32'b10);
    check("tripped_interval", 32'(interval), 32'd14);
    ack = 1'b1;
    step();
    ack = 1'b0; enable = 1'b0;
    step();
    check("tripped_ack_ignored", 32'(ack_count), 32'd101);
    check("tripped_sticky", 32'(err), 32'd1);

    // Recovery via clear, then re-arm.
    enable = 1'b1; clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_to_idle", 32'({err, armed, timeout}), 32'd0);
    check("clear_zeroes", 32'({interval, ack_count}), 32'd0);
    step();
    check("rearm_after_clear", 32'(armed), 32'd1);

    // Held ack counts every cycle; clear beats a simultaneous ack.
    ack = 1'b1;
    idle_cycles(2);
    check("held_ack_counts", 32'(ack_count), 32'd2);
    clear = 1'b1;
    step();
    clear = 1'b0; ack = 1'b0;
    check("clear_beats_ack", 32'(ack_count), 32'd0);
    check("clear_keeps_armed", 32'({armed, interval}), 32'({1'b1, 8'd0}));

`ifdef ACK_WATCHDOG_STATS_EN
    check("stats_after_clear", 32'({min_interval, max_interval}), 32'({8'hff, 8'h00}));
    idle_cycles(3);  ack = 1'b1; step(); ack = 1'b0;
    idle_cycles(9);  ack = 1'b1; step(); ack = 1'b0;
    idle_cycles(5);  ack = 1'b1; step(); ack = 1'b0;
    check("stats_min", 32'(min_interval), 32'd3);
    check("stats_max", 32'(max_interval), 32'd9);
`endif

    // Reset mid-window discards the count and never pulses timeout.
    idle_cycles(7);
    rst = 1'b1;
    step();
    check("midwin_reset_outputs", 32'({armed, timeout, err, interval, ack_count}), 32'd0);
`ifdef ACK_WATCHDOG_STATS_EN
    check("stats_reset", 32'({min_interval, max_interval}), 32'({8'hff, 8'h00}));
`endif
    rst = 1'b0; enable = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // Hard stop in case a loop above stalls.
  initial begin
    #200000;
    $display("FAIL watchdog_timeout: got hang expected finish");
    $fatal(1, "simulation time limit");
  end
endmodule
